// File: rtl/llc_if.sv
// Command/result bundle between the trace driver and the last-level cache model.
// Cache entries are packed as {valid, tag[11:0], mesi[1:0]}.
interface llc_if;
  localparam int NUM_SETS      = 16384;
  localparam int ASSOCIATIVITY = 16;

  logic [31:0] addr;
  int          op;
  int          cacheRds;
  int          cacheWrs;
  int          cacheHits;
  int          cacheMisses;
  logic [2:0]  busOp;
  logic [1:0]  snoopResult;
  logic [2:0]  message;
  logic [14:0] LLC_cache [NUM_SETS][ASSOCIATIVITY];

  modport master (
    output addr, op,
    input  cacheRds, cacheWrs, cacheHits, cacheMisses,
    input  busOp, snoopResult, message, LLC_cache
  );

  modport slave (
    input  addr, op,
    output cacheRds, cacheWrs, cacheHits, cacheMisses,
    output busOp, snoopResult, message, LLC_cache
  );
endinterface

// File: rtl/llc.sv
// Trace-driven last-level cache: 16-way, 16384 sets, MESI coherence and
// tree pseudo-LRU; one command executes per clock, all results registered.
package LLC_defs;
  typedef enum logic [1:0] {INVALID = 2'd0, SHARED = 2'd1, EXCLUSIVE = 2'd2, MODIFIED = 2'd3} mesi;
  typedef enum logic [2:0] {NOOP = 3'd0, READ = 3'd1, WRITE = 3'd2, INVALIDATE = 3'd3, RWIM = 3'd4} busOperation;
  typedef enum logic [1:0] {NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2} snoopResults;
  typedef enum logic [2:0] {NONE = 3'd0, GETLINE = 3'd1, SENDLINE = 3'd2, INVALIDATELINE = 3'd3, EVICTLINE = 3'd4} messages;
  typedef struct packed {
    logic        valid;
    logic [11:0] tag;
    mesi         state;
  } cache;
endpackage

module llc
  import LLC_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  llc_if.slave bus
);
  localparam int NUM_SETS      = 16384;
  localparam int ASSOCIATIVITY = 16;

  logic [14:0] plru_r [NUM_SETS];
  logic [13:0] idx_s;
  logic [11:0] tag_s;
  logic [3:0]  addr_unused;
  logic [15:0] match_s;
  logic [15:0] free_s;
  logic        hit_s;
  logic [3:0]  hit_way_s;
  logic [3:0]  fill_way_s;
  mesi         hit_state_s;
  snoopResults sim_snoop_s;
  mesi         fill_read_state_s;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Walk the tree: bit 0 steers left, leaves 15..30 map to ways 0..15.
  function automatic logic [3:0] plru_victim(input logic [14:0] bits);
    int n;
    n = 0;
    for (int l = 0; l < 4; l++) n = 2 * n + 1 + int'(bits[n]);
    return 4'(n - 15);
  endfunction

  function automatic logic [14:0] plru_touch(input logic [14:0] bits, input logic [3:0] way);
    logic [14:0] nb;
    int          n;
    nb = bits;
    n  = 0;
    for (int l = 0; l < 4; l++) begin
      nb[n] = ~way[3-l];
      n     = 2 * n + 1 + int'(way[3-l]);
    end
    return nb;
  endfunction

  function automatic logic [14:0] mk_entry(input logic v, input logic [11:0] t, input mesi s);
    cache c;
    c = '{valid: v, tag: t, state: s};
    return c;
  endfunction

  assign idx_s       = bus.addr[19:6];
  assign tag_s       = bus.addr[31:20];
  assign addr_unused = bus.addr[5:2];

  // Per-way tag match and free-way detection for the addressed set.
  always_comb begin
    match_s = 16'd0;
    free_s  = 16'd0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      free_s[w]  = ~bus.LLC_cache[idx_s][w][14] | (bus.LLC_cache[idx_s][w][1:0] == 2'd0);
      match_s[w] = ~free_s[w] & (bus.LLC_cache[idx_s][w][13:2] == tag_s);
    end
  end

  assign hit_s             = |match_s;
  assign hit_way_s         = lowest_set(match_s);
  assign hit_state_s       = mesi'(bus.LLC_cache[idx_s][hit_way_s][1:0]);
  assign fill_way_s        = (|free_s) ? lowest_set(free_s) : plru_victim(plru_r[idx_s]);
  assign sim_snoop_s       = (bus.addr[1:0] == 2'b00) ? HIT : ((bus.addr[1:0] == 2'b01) ? HITM : NOHIT);
  assign fill_read_state_s = (sim_snoop_s == NOHIT) ? EXCLUSIVE : SHARED;

  // Command execution: array, PLRU, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_r[s] <= 15'd0;
        for (int w = 0; w < ASSOCIATIVITY; w++) bus.LLC_cache[s][w] <= 15'd0;
      end
      bus.cacheRds    <= 32'sd0;
      bus.cacheWrs    <= 32'sd0;
      bus.cacheHits   <= 32'sd0;
      bus.cacheMisses <= 32'sd0;
      bus.busOp       <= NOOP;
      bus.snoopResult <= NOHIT;
      bus.message     <= NONE;
    end else begin
      bus.busOp       <= NOOP;
      bus.snoopResult <= NOHIT;
      bus.message     <= NONE;
      case (bus.op)
        32'sd0, 32'sd2: begin
          bus.cacheRds <= bus.cacheRds + 32'sd1;
          bus.message  <= SENDLINE;
          if (hit_s) begin
            bus.cacheHits  <= bus.cacheHits + 32'sd1;
            plru_r[idx_s]  <= plru_touch(plru_r[idx_s], hit_way_s);
          end else begin
            bus.cacheMisses <= bus.cacheMisses + 32'sd1;
            bus.busOp       <= READ;
            bus.snoopResult <= sim_snoop_s;
            bus.LLC_cache[idx_s][fill_way_s] <= mk_entry(1'b1, tag_s, fill_read_state_s);
            plru_r[idx_s]   <= plru_touch(plru_r[idx_s], fill_way_s);
          end
        end
        32'sd1: begin
          bus.cacheWrs <= bus.cacheWrs + 32'sd1;
          bus.message  <= SENDLINE;
          if (hit_s) begin
            bus.cacheHits <= bus.cacheHits + 32'sd1;
            bus.busOp     <= (hit_state_s == SHARED) ? INVALIDATE : NOOP;
            bus.LLC_cache[idx_s][hit_way_s] <= mk_entry(1'b1, tag_s, MODIFIED);
            plru_r[idx_s] <= plru_touch(plru_r[idx_s], hit_way_s);
          end else begin
            bus.cacheMisses <= bus.cacheMisses + 32'sd1;
            bus.busOp       <= RWIM;
            bus.snoopResult <= sim_snoop_s;
            bus.LLC_cache[idx_s][fill_way_s] <= mk_entry(1'b1, tag_s, MODIFIED);
            plru_r[idx_s]   <= plru_touch(plru_r[idx_s], fill_way_s);
          end
        end
        32'sd3: begin
          if (hit_s) begin
            case (hit_state_s)
              MODIFIED: begin
                bus.snoopResult <= HITM;
                bus.busOp       <= WRITE;
                bus.message     <= GETLINE;
                bus.LLC_cache[idx_s][hit_way_s] <= mk_entry(1'b1, tag_s, SHARED);
              end
              EXCLUSIVE: begin
                bus.snoopResult <= HIT;
                bus.LLC_cache[idx_s][hit_way_s] <= mk_entry(1'b1, tag_s, SHARED);
              end
              SHARED:  bus.snoopResult <= HIT;
              default: bus.snoopResult <= NOHIT;
            endcase
          end else begin
            bus.snoopResult <= NOHIT;
          end
        end
        32'sd5: begin
          if (hit_s) begin
            case (hit_state_s)
              MODIFIED: begin
                bus.snoopResult <= HITM;
                bus.busOp       <= WRITE;
                bus.message     <= EVICTLINE;
                bus.LLC_cache[idx_s][hit_way_s] <= mk_entry(1'b0, tag_s, INVALID);
              end
              EXCLUSIVE, SHARED: begin
                bus.snoopResult <= HIT;
                bus.message     <= INVALIDATELINE;
                bus.LLC_cache[idx_s][hit_way_s] <= mk_entry(1'b0, tag_s, INVALID);
              end
              default: bus.snoopResult <= NOHIT;
            endcase
          end else begin
            bus.snoopResult <= NOHIT;
          end
        end
        32'sd6: begin
          if (hit_s && (hit_state_s == SHARED)) begin
            bus.snoopResult <= HIT;
            bus.message     <= INVALIDATELINE;
            bus.LLC_cache[idx_s][hit_way_s] <= mk_entry(1'b0, tag_s, INVALID);
          end else begin
            bus.snoopResult <= NOHIT;
          end
        end
        32'sd8: begin
          for (int s = 0; s < NUM_SETS; s++) begin
            plru_r[s] <= 15'd0;
            for (int w = 0; w < ASSOCIATIVITY; w++) bus.LLC_cache[s][w] <= 15'd0;
          end
          bus.cacheRds    <= 32'sd0;
          bus.cacheWrs    <= 32'sd0;
          bus.cacheHits   <= 32'sd0;
          bus.cacheMisses <= 32'sd0;
        end
        default: bus.message <= NONE;
      endcase
    end
  end
endmodule

// File: tb/tb_llc.sv
// Directed table-driven bench for the llc cache model plus hand-written
// sequences for replacement, clear and asynchronous reset.
module tb_llc;
  import LLC_defs::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  llc_if bus ();

  llc dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [2:0]  bop;
    logic [1:0]  snp;
    logic [2:0]  msg;
    int          way;
    logic [1:0]  st;
    int          rds;
    int          wrs;
    int          hits;
    int          miss;
  } vec_t;

  vec_t tab [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int o, input logic [31:0] a);
    @(negedge clk);
    bus.op   = o;
    bus.addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] b, input logic [1:0] s, input logic [2:0] m);
    chk({tag, ".busOp"}, 32'(bus.busOp), 32'(b));
    chk({tag, ".snoop"}, 32'(bus.snoopResult), 32'(s));
    chk({tag, ".msg"}, 32'(bus.message), 32'(m));
  endtask

  task automatic chk_cnts(input string tag, input int r, input int w, input int h, input int m);
    chk({tag, ".rds"}, bus.cacheRds, r);
    chk({tag, ".wrs"}, bus.cacheWrs, w);
    chk({tag, ".hits"}, bus.cacheHits, h);
    chk({tag, ".misses"}, bus.cacheMisses, m);
  endtask

  task automatic chk_all_invalid(input string tag);
    int bad;
    bad = 0;
    for (int s = 0; s < 16384; s++)
      for (int w = 0; w < 16; w++)
        if (bus.LLC_cache[s][w] !== 15'd0) bad++;
    chk({tag, ".array_nonzero"}, bad, 0);
  endtask

  initial begin
    logic [14:0] e;
    checks   = 0;
    failures = 0;

    //          op addr           busOp       snoop  message         way state      rds wrs hit miss
    tab[0]  = '{0, 32'h1000_0002, READ,       NOHIT, SENDLINE,       0, EXCLUSIVE, 1, 0, 0, 1};
    tab[1]  = '{0, 32'h1000_0002, NOOP,       NOHIT, SENDLINE,       0, EXCLUSIVE, 2, 0, 1, 1};
    tab[2]  = '{1, 32'h1000_0002, NOOP,       NOHIT, SENDLINE,       0, MODIFIED,  2, 1, 2, 1};
    tab[3]  = '{3, 32'h1000_0002, WRITE,      HITM,  GETLINE,        0, SHARED,    2, 1, 2, 1};
    tab[4]  = '{6, 32'h1000_0002, NOOP,       HIT,   INVALIDATELINE, 0, INVALID,   2, 1, 2, 1};
    tab[5]  = '{0, 32'h2000_0000, READ,       HIT,   SENDLINE,       0, SHARED,    3, 1, 2, 2};
    tab[6]  = '{1, 32'h2000_0000, INVALIDATE, NOHIT, SENDLINE,       0, MODIFIED,  3, 2, 3, 2};
    tab[7]  = '{5, 32'h2000_0000, WRITE,      HITM,  EVICTLINE,      0, INVALID,   3, 2, 3, 2};
    tab[8]  = '{4, 32'h2000_0000, NOOP,       NOHIT, NONE,           0, INVALID,   3, 2, 3, 2};
    tab[9]  = '{0, 32'h3000_0001, READ,       HITM,  SENDLINE,       0, SHARED,    4, 2, 3, 3};
    tab[10] = '{9, 32'h3000_0001, NOOP,       NOHIT, NONE,           0, SHARED,    4, 2, 3, 3};
    tab[11] = '{7, 32'h3000_0001, NOOP,       NOHIT, NONE,           0, SHARED,    4, 2, 3, 3};
    tab[12] = '{-1, 32'h3000_0001, NOOP,      NOHIT, NONE,           0, SHARED,    4, 2, 3, 3};
    tab[13] = '{3, 32'h3000_0001, NOOP,       HIT,   NONE,           0, SHARED,    4, 2, 3, 3};
    tab[14] = '{1, 32'h4000_0003, RWIM,       NOHIT, SENDLINE,       1, MODIFIED,  4, 3, 3, 4};
    tab[15] = '{4, 32'h4000_0003, NOOP,       NOHIT, NONE,           1, MODIFIED,  4, 3, 3, 4};
    tab[16] = '{3, 32'h4000_0003, WRITE,      HITM,  GETLINE,        1, SHARED,    4, 3, 3, 4};
    tab[17] = '{5, 32'h3000_0001, NOOP,       HIT,   INVALIDATELINE, 0, INVALID,   4, 3, 3, 4};

    rst_n    = 1'b0;
    bus.op   = 9;
    bus.addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", NOOP, NOHIT, NONE);
    chk_cnts("reset", 0, 0, 0, 0);
    chk("reset.way0", 32'(bus.LLC_cache[0][0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      step(tab[i].op, tab[i].addr);
      chk_outs(nm, tab[i].bop, tab[i].snp, tab[i].msg);
      chk_cnts(nm, tab[i].rds, tab[i].wrs, tab[i].hits, tab[i].miss);
      e = bus.LLC_cache[tab[i].addr[19:6]][tab[i].way];
      chk({nm, ".state"}, 32'(e[1:0]), 32'(tab[i].st));
      if (tab[i].st != INVALID) begin
        chk({nm, ".valid"}, 32'(e[14]), 32'd1);
        chk({nm, ".tag"}, 32'(e[13:2]), 32'(tab[i].addr[31:20]));
      end
    end

    step(8, 32'h0);
    chk_outs("op8", NOOP, NOHIT, NONE);
    chk_cnts("op8", 0, 0, 0, 0);
    chk_all_invalid("op8");

    // Fill all 16 ways of set 0, then force PLRU replacement twice.
    for (int t = 1; t <= 18; t++) begin
      logic [31:0] a;
      a = {12'(t), 20'h0};
      step(0, a);
      chk($sformatf("fill%0d.busOp", t), 32'(bus.busOp), 32'(READ));
      if (t <= 16)
        chk($sformatf("fill%0d.tag", t), 32'(bus.LLC_cache[0][t-1][13:2]), 32'(t));
    end
    chk("plru17.way0", 32'(bus.LLC_cache[0][0]), {17'h0, 1'b1, 12'h011, 2'd1});
    chk("plru17.way1", 32'(bus.LLC_cache[0][1][13:2]), 32'h002);
    chk("plru18.way8", 32'(bus.LLC_cache[0][8][13:2]), 32'h012);
    chk("plru18.way9", 32'(bus.LLC_cache[0][9][13:2]), 32'h00a);
    chk_cnts("fill", 18, 0, 0, 18);

    // Asynchronous reset between clock edges, with a live command applied.
    step(0, 32'h1000_0002);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("arst", NOOP, NOHIT, NONE);
    chk_cnts("arst", 0, 0, 0, 0);
    chk_all_invalid("arst");
    @(posedge clk);
    #1;
    chk("arst_hold.rds", bus.cacheRds, 0);
    @(negedge clk);
    bus.op = 9;
    rst_n  = 1'b1;
    step(0, 32'h1000_0002);
    chk_outs("post_rst", READ, NOHIT, SENDLINE);
    chk_cnts("post_rst", 1, 0, 0, 1);
    chk("post_rst.way0", 32'(bus.LLC_cache[0][0]), {17'h0, 1'b1, 12'h100, 2'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
